multi_clock_divider: RTL

Parametrised, multi-channel, runtime-programmable clock divider. Each of NUM_CH channels generates a 50%-duty divided clock with period 2·HP input cycles, a one-cycle rising-edge strobe, and a per-channel run enable. New half-period values are loaded at any time and applied glitch-free only at a period boundary. It replaces the fixed divide-by-10 divider and feeds the slower hashing/control domains.

---
 rtl/multi_clock_divider_if.sv | 34 +++
 rtl/multi_clock_divider.sv | 98 +++++++++
 2 files changed

// File: rtl/multi_clock_divider_if.sv
// multi_clock_divider_if
//   Bundles the per-channel control and status vectors of the clock divider.
//   Parameters:
//     NUM_CH : number of divider channels
//     CNT_W  : width of each half-period value
//   Signals:
//     en          per-channel run enable            (master -> slave)
//     half_period packed half-period values,        (master -> slave)
//                 channel i at [i*CNT_W +: CNT_W]
//     load        per-channel capture pulse         (master -> slave)
//     clk_div     per-channel divided clock         (slave -> master)
//     tick        per-channel rising-edge strobe    (slave -> master)
//     pending     per-channel "value waiting" flag  (slave -> master)
interface multi_clock_divider_if #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 8
) ();
  logic [NUM_CH-1:0]       en;
  logic [NUM_CH*CNT_W-1:0] half_period;
  logic [NUM_CH-1:0]       load;
  logic [NUM_CH-1:0]       clk_div;
  logic [NUM_CH-1:0]       tick;
  logic [NUM_CH-1:0]       pending;

  modport master (
    output en, half_period, load,
    input  clk_div, tick, pending
  );

  modport slave (
    input  en, half_period, load,
    output clk_div, tick, pending
  );
endinterface

// File: rtl/multi_clock_divider.sv
// multi_clock_divider
//   Multi-channel, runtime-programmable 50%-duty clock divider. Each channel
//   produces clk_div with period 2*HP clk cycles, a one-cycle tick on every
//   clk_div rising edge and a pending flag while a newly loaded half-period
//   waits for the next period boundary (clk_div falling edge, or immediately
//   when the channel is idle with clk_div low).
//   Ports:
//     clk   : system clock, all logic on the rising edge
//     n_rst : asynchronous active-low reset
//     bus   : multi_clock_divider_if.slave (en, half_period, load in;
//             clk_div, tick, pending out, all registered)
module multi_clock_divider #(
  parameter int NUM_CH   = 2,
  parameter int CNT_W    = 8,
  parameter int RESET_HP = 5
) (
  input  logic                     clk,
  input  logic                     n_rst,
  multi_clock_divider_if.slave     bus
);

  logic [NUM_CH-1:0] clk_div_vec;
  logic [NUM_CH-1:0] tick_vec;
  logic [NUM_CH-1:0] pending_vec;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [CNT_W-1:0] count_reg;
      logic [CNT_W-1:0] active_hp_reg;
      logic [CNT_W-1:0] pend_hp_reg;
      logic             pend_reg;
      logic             clk_div_reg;
      logic             tick_reg;

      logic [CNT_W-1:0] eff_m1;
      logic             terminal;
      logic             apply;

      always_comb begin
        // A half-period of 0 behaves like 1, so eff-1 is 0 in both cases.
        eff_m1   = (active_hp_reg == '0) ? '0 : (active_hp_reg - CNT_W'(1));
        // >= rather than == so a count stranded above a freshly shrunk
        // half-period terminates at once instead of wrapping.
        terminal = (count_reg >= eff_m1);
        // Boundaries: running and about to fall, or idle with the level low.
        apply    = pend_reg && (bus.en[gi] ? (terminal && clk_div_reg)
                                           : !clk_div_reg);
      end

      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
          count_reg     <= '0;
          active_hp_reg <= CNT_W'(RESET_HP);
          pend_hp_reg   <= '0;
          pend_reg      <= 1'b0;
          clk_div_reg   <= 1'b0;
          tick_reg      <= 1'b0;
        end else begin
          tick_reg <= 1'b0;
          if (bus.en[gi]) begin
            if (terminal) begin
              count_reg   <= '0;
              clk_div_reg <= ~clk_div_reg;
              tick_reg    <= ~clk_div_reg;
            end else begin
              count_reg <= count_reg + CNT_W'(1);
            end
          end else if (apply) begin
            count_reg <= '0;
          end

          // The apply uses the registered pend_hp, so a coincident load is
          // kept for the following boundary.
          if (apply) begin
            active_hp_reg <= pend_hp_reg;
          end

          if (bus.load[gi]) begin
            pend_hp_reg <= bus.half_period[gi*CNT_W +: CNT_W];
            pend_reg    <= 1'b1;
          end else if (apply) begin
            pend_reg <= 1'b0;
          end
        end
      end

      assign clk_div_vec[gi] = clk_div_reg;
      assign tick_vec[gi]    = tick_reg;
      assign pending_vec[gi] = pend_reg;
    end
  endgenerate

  assign bus.clk_div = clk_div_vec;
  assign bus.tick    = tick_vec;
  assign bus.pending = pending_vec;

endmodule
